// File: rtl/dcache_wb_direct.sv
// dcache_wb_direct: direct-mapped, write-back, write-allocate data cache with 4-word blocks
//   clk, rst_n                : clock, synchronous active-low reset
//   proc_ren/wen/addr/wdata   : word-addressed request from MEM stage (both enables high = write)
//   proc_rdata, proc_stall    : read data (combinational on hit), request-not-complete
//   mem_ren/wen/addr/wdata    : registered block request toward main memory
//   mem_rdata, mem_ready      : refill block, one-cycle completion pulse
module dcache_wb_direct #(
  parameter int NUM_LINES = 8,
  parameter int BIT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               proc_ren,
  input  logic               proc_wen,
  input  logic [29:0]        proc_addr,
  input  logic [BIT_W-1:0]   proc_wdata,
  output logic [BIT_W-1:0]   proc_rdata,
  output logic               proc_stall,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [27:0]        mem_addr,
  output logic [4*BIT_W-1:0] mem_wdata,
  input  logic [4*BIT_W-1:0] mem_rdata,
  input  logic               mem_ready
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [4*BIT_W-1:0]   data_q [NUM_LINES];
  logic [BIT_W-1:0]     rdata_q, word;
  logic                 mem_ren_q, mem_wen_q;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [1:0]           off;
  logic                 req, hit, rd_hit, wr_hit;
  assign off = proc_addr[1:0];
  assign idx = proc_addr[IDX_W+1:2];
  assign tag = proc_addr[29:IDX_W+2];
  assign req = proc_ren | proc_wen;
  // hits are only acted on in IDLE; during a miss the line is being replaced
  assign hit    = req & (state_q == IDLE) & valid_q[idx] & (tag_q[idx] == tag);
  assign rd_hit = hit & ~proc_wen;
  assign wr_hit = hit & proc_wen;
  assign word       = data_q[idx][BIT_W*off +: BIT_W];
  assign proc_rdata = rd_hit ? word : rdata_q;
  assign proc_stall = (state_q != IDLE) | (req & ~hit);
  assign mem_ren    = mem_ren_q;
  assign mem_wen    = mem_wen_q;
  // the array is untouched during WRITEBACK, so victim tag/data stay stable until mem_ready
  assign mem_addr   = (state_q == WRITEBACK) ? {tag_q[idx], idx} : {tag, idx};
  assign mem_wdata  = data_q[idx];
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (req & ~hit) state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
    end else if (mem_ready) begin
      state_d = (state_q == WRITEBACK) ? ALLOCATE : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_ren_q <= state_d == ALLOCATE;
      mem_wen_q <= state_d == WRITEBACK;
      if (rd_hit) rdata_q <= word;
      if (wr_hit) begin
        data_q[idx][BIT_W*off +: BIT_W] <= proc_wdata;
        dirty_q[idx] <= 1'b1;
      end
      if (state_q == WRITEBACK && mem_ready) dirty_q[idx] <= 1'b0;
      if (state_q == ALLOCATE && mem_ready) begin
        data_q[idx]  <= mem_rdata;
        tag_q[idx]   <= tag;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dcache_wb_direct.sv
// tb_dcache_wb_direct: vector table plus hand sequences against a latency-4 block memory model
module tb_dcache_wb_direct;
  localparam int LAT = 4;
  typedef struct {
    logic        ren, wen;
    logic [29:0] addr;
    logic [31:0] wdata, rdata;
    int          stall, wb;
    logic [27:0] wb_addr, rd_addr;
    int          wb_off;
    logic [31:0] wb_word;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, proc_ren, proc_wen, proc_stall, mem_ren, mem_wen, mem_ready, force_rdy;
  logic mem_ready_m = 1'b0;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata, proc_rdata;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  int n_err = 0, n_chk = 0;
  int cnt = 0, wb_cnt = 0, wen_cyc = 0, both_hi = 0, unstable = 0, viol = 0, wn = 0;
  logic [27:0]  wb_addr = '0, rd_addr = '0, pa = '0;
  logic [127:0] wb_data = '0, pd = '0;
  logic         pw = 1'b0, pstall = 1'b0, prst = 1'b0;
  logic [63:0]  preq = '0;
  logic [27:0]  wa [8];
  logic [127:0] wd [8];
  logic [31:0]  exp_q [$];
  vec_t tbl [15];
  always #5 clk = ~clk;
  assign mem_ready = mem_ready_m | force_rdy;
  dcache_wb_direct dut (
    .clk(clk), .rst_n(rst_n), .proc_ren(proc_ren), .proc_wen(proc_wen),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  function automatic logic [127:0] blk(input logic [27:0] a);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[32*w +: 32] = {a[23:0], 8'(8'h11 * w)};
    for (int i = 0; i < 8; i++) if (i < wn && wa[i] == a) b = wd[i];
    return b;
  endfunction
  always @(posedge clk) begin
    mem_ready_m <= 1'b0;
    if (mem_ren && mem_wen) both_hi <= both_hi + 1;
    if (mem_wen) wen_cyc <= wen_cyc + 1;
    if (mem_wen && pw && (mem_addr != pa || mem_wdata != pd)) unstable <= unstable + 1;
    pw <= mem_wen;
    pa <= mem_addr;
    pd <= mem_wdata;
    if (!rst_n) cnt <= 0;
    else if ((mem_ren || mem_wen) && !mem_ready_m) begin
      if (cnt == LAT - 1) begin
        cnt         <= 0;
        mem_ready_m <= 1'b1;
        mem_rdata   <= blk(mem_addr);
        if (mem_wen) begin
          wa[wn % 8] <= mem_addr;
          wd[wn % 8] <= mem_wdata;
          wn         <= wn + 1;
          wb_cnt     <= wb_cnt + 1;
          wb_addr    <= mem_addr;
          wb_data    <= mem_wdata;
        end else rd_addr <= mem_addr;
      end else cnt <= cnt + 1;
    end else cnt <= 0;
  end
  always @(posedge clk) begin
    if (rst_n && prst && pstall && {proc_ren, proc_wen, proc_addr, proc_wdata} != preq) viol <= viol + 1;
    preq   <= {proc_ren, proc_wen, proc_addr, proc_wdata};
    pstall <= proc_stall;
    prst   <= rst_n;
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic access(input vec_t v, input string nm);
    int cyc, wb0, wen0;
    logic [31:0] e;
    @(negedge clk);
    proc_ren = v.ren; proc_wen = v.wen; proc_addr = v.addr; proc_wdata = v.wdata;
    wb0 = wb_cnt; wen0 = wen_cyc; cyc = 0;
    if (v.ren && !v.wen) exp_q.push_back(v.rdata);
    #1;
    while (proc_stall && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    check($sformatf("%s_stall", nm), cyc, v.stall);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_rdata", nm), proc_rdata, e);
    end
    check($sformatf("%s_wb", nm), wb_cnt - wb0, v.wb);
    check($sformatf("%s_wen", nm), wen_cyc != wen0, v.wb != 0);
    if (v.wb != 0) begin
      check($sformatf("%s_wb_addr", nm), wb_addr, v.wb_addr);
      check($sformatf("%s_wb_word", nm), wb_data[32*v.wb_off +: 32], v.wb_word);
    end
    if (v.stall != 0) check($sformatf("%s_rd_addr", nm), rd_addr, v.rd_addr);
  endtask
  initial begin
    rst_n = 1'b0; proc_ren = 1'b0; proc_wen = 1'b0; proc_addr = '0; proc_wdata = '0; force_rdy = 1'b0;
    tbl[0]  = '{1'b1, 1'b0, 30'h4,        32'h0,        32'h100,      6,  0, 28'h0,  28'h1,       0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 30'h5,        32'h0,        32'h111,      0,  0, 28'h0,  28'h0,       0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 30'h6,        32'hDEADBEEF, 32'h0,        0,  0, 28'h0,  28'h0,       0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 30'h6,        32'h0,        32'hDEADBEEF, 0,  0, 28'h0,  28'h0,       0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 30'h26,       32'h0,        32'h922,      11, 1, 28'h1,  28'h9,       2, 32'hDEADBEEF};
    tbl[5]  = '{1'b1, 1'b0, 30'h6,        32'h0,        32'hDEADBEEF, 6,  0, 28'h0,  28'h1,       0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 30'h40,       32'h12345678, 32'h0,        6,  0, 28'h0,  28'h10,      0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 30'h40,       32'h0,        32'h12345678, 0,  0, 28'h0,  28'h0,       0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 30'h41,       32'h0,        32'h1011,     0,  0, 28'h0,  28'h0,       0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 30'h0,        32'h0,        32'h0,        11, 1, 28'h10, 28'h0,       0, 32'h12345678};
    tbl[10] = '{1'b1, 1'b1, 30'h1,        32'hCAFEF00D, 32'h0,        0,  0, 28'h0,  28'h0,       0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 30'h1,        32'h0,        32'hCAFEF00D, 0,  0, 28'h0,  28'h0,       0, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 30'h3FFFFFFF, 32'hFFFFFFFF, 32'h0,        6,  0, 28'h0,  28'hFFFFFFF, 0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 30'h3FFFFFFF, 32'h0,        32'hFFFFFFFF, 0,  0, 28'h0,  28'h0,       0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 30'h3FFFFFFC, 32'h0,        32'hFFFFFF00, 0,  0, 28'h0,  28'h0,       0, 32'h0};
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_mem_ren", mem_ren, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_stall", proc_stall, 0);
    check("rst_rdata", proc_rdata, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) access(tbl[i], $sformatf("v%0d", i));
    @(negedge clk);
    proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h8;
    #1 check("rstmid_miss_stall", proc_stall, 1);
    @(negedge clk); #1;
    check("rstmid_mem_ren_before", mem_ren, 1);
    @(negedge clk);
    rst_n = 1'b0; proc_ren = 1'b0;
    @(negedge clk); #1;
    check("rstmid_mem_ren", mem_ren, 0);
    check("rstmid_mem_wen", mem_wen, 0);
    check("rstmid_stall", proc_stall, 0);
    rst_n = 1'b1;
    access('{1'b1, 1'b0, 30'h8, 32'h0, 32'h200,      6, 0, 28'h0, 28'h2, 0, 32'h0}, "rstmid_refetch");
    access('{1'b1, 1'b0, 30'h6, 32'h0, 32'hDEADBEEF, 6, 0, 28'h0, 28'h1, 0, 32'h0}, "rstmid_inval");
    @(negedge clk);
    proc_ren = 1'b0; proc_wen = 1'b0; force_rdy = 1'b1;
    #1 check("idle_rdy_stall", proc_stall, 0);
    @(negedge clk);
    force_rdy = 1'b0;
    #1;
    check("idle_rdy_stall_after", proc_stall, 0);
    check("idle_rdy_mem_ren", mem_ren, 0);
    check("idle_rdy_mem_wen", mem_wen, 0);
    access('{1'b1, 1'b0, 30'h8, 32'h0, 32'h200, 0, 0, 28'h0, 28'h0, 0, 32'h0}, "idle_rdy_hit");
    @(negedge clk);
    proc_ren = 1'b0; proc_wen = 1'b0;
    repeat (2) @(negedge clk);
    check("mem_ren_wen_both_high", both_hi, 0);
    check("wb_outputs_stable", unstable, 0);
    check("req_stable_during_stall", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
